// File: rtl/mem_port.sv
// Data-memory port: turns control-unit load/store requests into single SRAM strobes,
// aligns and extends load data, and signals completion with a one-cycle pulse.
module mem_port #(
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] ADDR_LIMIT  = 32'h80000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [3:0]  mem_size,
    input  logic        mem_addr_ready,
    output logic        mem_data_ready,
    output logic [31:0] rdata,
    output logic        rdata_en,
    output logic [29:0] sram_addr,
    output logic [3:0]  sram_be,
    output logic        sram_re,
    output logic        sram_we,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    typedef enum logic [1:0] {StIdle, StAccess, StWait, StDone} state_e;

    localparam logic [2:0] WaitLoad = 3'(WAIT_STATES - 1);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [1:0]  lane_q;
    logic [3:0]  size_q;
    logic        is_read_q, oob_q;

    logic        accept, in_range, is_byte, is_half;
    logic [3:0]  lane_mask;
    logic [31:0] store_word;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_v;

    logic        mem_data_ready_d, rdata_en_d, sram_re_d, sram_we_d;
    logic [31:0] rdata_d, sram_wdata_d;
    logic [29:0] sram_addr_d;
    logic [3:0]  sram_be_d;

    assign accept   = (state_q == StIdle) && mem_addr_ready && (mem_read || mem_write);
    assign in_range = addr < ADDR_LIMIT;
    assign is_byte  = mem_size[3] | mem_size[2];
    assign is_half  = mem_size[1] | mem_size[0];

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) state_d = StAccess;
            end
            StAccess: begin
                if (oob_q || WAIT_STATES == 0) begin
                    state_d = StDone;
                end else begin
                    state_d = StWait;
                    cnt_d   = WaitLoad;
                end
            end
            StWait: begin
                if (cnt_q == 3'd0) state_d = StDone;
                else               cnt_d = cnt_q - 3'd1;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Store lane selection and data replication
    always_comb begin
        if (is_byte) begin
            lane_mask  = 4'b0001 << addr[1:0];
            store_word = {4{wdata[7:0]}};
        end else if (is_half) begin
            lane_mask  = addr[1] ? 4'b1100 : 4'b0011;
            store_word = {2{wdata[15:0]}};
        end else begin
            lane_mask  = 4'b1111;
            store_word = wdata;
        end
    end

    // Load alignment and extension
    always_comb begin
        unique case (lane_q)
            2'd0: byte_v = sram_rdata[7:0];
            2'd1: byte_v = sram_rdata[15:8];
            2'd2: byte_v = sram_rdata[23:16];
            2'd3: byte_v = sram_rdata[31:24];
        endcase
        half_v = lane_q[1] ? sram_rdata[31:16] : sram_rdata[15:0];
        if (size_q[3])      load_v = {{24{byte_v[7]}}, byte_v};
        else if (size_q[2]) load_v = {24'h0, byte_v};
        else if (size_q[1]) load_v = {{16{half_v[15]}}, half_v};
        else if (size_q[0]) load_v = {16'h0, half_v};
        else                load_v = sram_rdata;
    end

    // Output next-values; outputs are registered so strobes line up with ACCESS and DONE
    always_comb begin
        sram_re_d        = accept && mem_read && in_range;
        sram_we_d        = accept && !mem_read && mem_write && in_range;
        sram_be_d        = (accept && in_range) ? lane_mask : 4'b0000;
        sram_addr_d      = (accept && in_range) ? addr[31:2] : sram_addr;
        sram_wdata_d     = (accept && !mem_read && mem_write) ? store_word : sram_wdata;
        mem_data_ready_d = (state_d == StDone) && (state_q != StDone);
        rdata_en_d       = mem_data_ready_d && is_read_q;
        rdata_d          = rdata;
        if (mem_data_ready_d && is_read_q) rdata_d = oob_q ? 32'h0 : load_v;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane_q         <= 2'd0;
            size_q         <= 4'd0;
            is_read_q      <= 1'b0;
            oob_q          <= 1'b0;
            mem_data_ready <= 1'b0;
            rdata_en       <= 1'b0;
            rdata          <= 32'h0;
            sram_addr      <= 30'h0;
            sram_be        <= 4'h0;
            sram_re        <= 1'b0;
            sram_we        <= 1'b0;
            sram_wdata     <= 32'h0;
        end else begin
            if (accept) begin
                lane_q    <= addr[1:0];
                size_q    <= mem_size;
                is_read_q <= mem_read;
                oob_q     <= !in_range;
            end
            mem_data_ready <= mem_data_ready_d;
            rdata_en       <= rdata_en_d;
            rdata          <= rdata_d;
            sram_addr      <= sram_addr_d;
            sram_be        <= sram_be_d;
            sram_re        <= sram_re_d;
            sram_we        <= sram_we_d;
            sram_wdata     <= sram_wdata_d;
        end
    end

endmodule

// File: doc/mem_port.md
MEM_PORT -- requirements
Module: mem_port

Interface
REQ-001: Parameter WAIT_STATES, default 1, SHALL set the number of extra idle cycles between SRAM strobe and data capture (legal range 0-7).
REQ-002: Parameter ADDR_LIMIT, default 32'h80000, SHALL set the exclusive upper byte address served; the block SHALL NOT strobe the SRAM at or above it.
REQ-003: clk  in  1  single clock; all state changes on posedge.
REQ-004: reset  in  1  asynchronous, active-high reset.
REQ-005: addr  in  32  byte address from the control unit.
REQ-006: wdata  in  32  store data, taken from the shared data bus.
REQ-007: mem_read  in  1  read request level.
REQ-008: mem_write  in  1  write request level.
REQ-009: mem_size  in  4  one-hot {lb/sb, lbu, lh/sh, lhu}; 0 = word.
REQ-010: mem_addr_ready  in  1  address/request valid strobe from the control unit.
REQ-011: mem_data_ready  out  1  one-cycle completion pulse.
REQ-012: rdata  out  32  load result, already aligned and extended.
REQ-013: rdata_en  out  1  high while rdata drives the shared bus.
REQ-014: sram_addr  out  30  word address.
REQ-015: sram_be  out  4  byte-lane enables.
REQ-016: sram_re / sram_we  out  1 each  read and write strobes.
REQ-017: sram_wdata  out  32  lane-replicated store data.
REQ-018: sram_rdata  in  32  SRAM read word, valid WAIT_STATES+1 cycles after sram_re rises.

Function
REQ-019: The FSM SHALL have states IDLE, ACCESS, WAIT, DONE.
REQ-020: In IDLE, a request SHALL be accepted on a posedge where mem_addr_ready && (mem_read || mem_write); addr, wdata, mem_size and direction SHALL be latched at that edge.
REQ-021: When mem_read and mem_write are both high, the block SHALL perform the read and ignore the write.
REQ-022: ACCESS SHALL assert sram_re or sram_we with sram_addr = addr[31:2] for exactly one cycle; next state is WAIT when WAIT_STATES>0, otherwise DONE.
REQ-023: WAIT SHALL count WAIT_STATES cycles with a 3-bit down-counter, then go to DONE.
REQ-024: DONE SHALL pulse mem_data_ready for exactly one cycle, drive rdata_en for loads, and return to IDLE.
REQ-025: Accepted-to-mem_data_ready latency SHALL be WAIT_STATES+2 cycles.
REQ-026: Read extraction: byte = sram_rdata[8*addr[1:0] +: 8]; half = sram_rdata[16*addr[1] +: 16]; lb/lh sign-extend, lbu/lhu zero-extend, word passes through.
REQ-027: Store lanes: sb sets sram_be = 1<<addr[1:0] with the byte replicated ×4; sh sets be = addr[1] ? 1100 : 0011 with the half replicated ×2; sw sets be = 1111.
REQ-028: Word accesses SHALL ignore addr[1:0]; halfword accesses SHALL ignore addr[0]. Misalignment is trapped upstream.
REQ-029: A request with addr >= ADDR_LIMIT SHALL be accepted and skip the SRAM strobe, go directly to DONE, and return rdata = 0.
REQ-030: Requests arriving in any state other than IDLE SHALL be ignored, not queued.
REQ-031: A request still present in the cycle after DONE SHALL be accepted as a new transaction.
REQ-032: rdata SHALL hold its last value until the next load's DONE.
REQ-033: rdata_en and the SRAM strobes SHALL never be high outside DONE and ACCESS respectively.

Reset
REQ-034: Asserting reset SHALL immediately force IDLE and set mem_data_ready, rdata_en, sram_re, sram_we and sram_be to 0, and rdata, sram_addr and sram_wdata to 0.
REQ-035: Reset asserted during ACCESS or WAIT SHALL abort the transaction with no mem_data_ready pulse.
REQ-036: After reset deasserts, the first acceptance SHALL occur no earlier than the first posedge.

Verification
REQ-037: WAIT_STATES=1, fetch word at 0x100 with SRAM word 0x00500093 -> mem_data_ready pulses 3 cycles after acceptance; rdata = 0x00500093.
REQ-038: lb at 0x203 with SRAM word 0x80FF1234 -> rdata = 0xFFFFFF80; the same access as lbu -> 0x00000080.
REQ-039: lh at 0x202 with SRAM word 0x80FF1234 -> rdata = 0xFFFF80FF; lhu at 0x200 -> 0x00001234.
REQ-040: sb of wdata 0x000000AB at 0x105 -> sram_be = 0010, sram_wdata = 0xABABABAB, sram_addr = 0x41; sh of 0x0000BEEF at 0x106 -> sram_be = 1100.
REQ-041: Load at 0x80000 -> no sram_re; mem_data_ready pulses 2 cycles after acceptance; rdata = 0.
REQ-042: WAIT_STATES=3, reset asserted in the second WAIT cycle -> all outputs 0 and no pulse; a new request at the next edge completes normally.
